// File: rtl/apb_pkg.sv
// Shared APB definitions for the APB requester and the APB RAM slave.
//   apb_state_e    : requester transfer phases (IDLE, SETUP, ACCESS, RESP)
//   APB_ADDR_W     : default address width
//   APB_DATA_W     : default data width
//   APB_RAM_DEPTH  : number of words in the APB RAM slave
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    localparam int APB_ADDR_W    = 32;
    localparam int APB_DATA_W    = 32;
    localparam int APB_RAM_DEPTH = 64;

endpackage

// File: rtl/apb_timeout_counter.sv
// Saturating ACCESS-phase wait counter for the APB requester.
//   pclk    in  clock
//   preset  in  synchronous active-high reset
//   clr     in  clear the count (requester not in ACCESS)
//   en      in  count this cycle (ACCESS without pready)
//   expired out this counted cycle brings the count to TIMEOUT_CYCLES
// TIMEOUT_CYCLES = 0 disables expiry; the count then stays at zero.
module apb_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic pclk,
    input  logic preset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_r;

    // Count waiting cycles, saturating at LIMIT so the value never wraps.
    always_ff @(posedge pclk) begin
        if (preset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (en && (cnt_r != LIMIT)) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Expiry is flagged in the cycle whose increment would reach LIMIT, so the
    // requester leaves ACCESS after exactly TIMEOUT_CYCLES waiting cycles.
    generate
        if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
            assign expired = 1'b0;
        end else begin : g_timeout
            assign expired = en && (cnt_r >= (LIMIT - CNT_W'(1)));
        end
    endgenerate

endmodule

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB requester: takes one valid/ready command, runs one
// APB SETUP/ACCESS transfer, and returns a valid/ready response.
//   pclk, preset                  clock, synchronous active-high reset
//   req_valid/req_ready           command handshake (ready only in IDLE)
//   req_write/req_addr/req_wdata  command fields
//   rsp_valid/rsp_ready           response handshake
//   rsp_rdata/rsp_slverr/rsp_timeout  response fields
//   psel/penable/pwrite/paddr/pwdata  APB request outputs (all registered)
//   prdata/pready/pslverr         APB completer inputs
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_W         = APB_ADDR_W,
    parameter int DATA_W         = APB_DATA_W,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_slverr,
    output logic              rsp_timeout,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    apb_state_e        state_r;
    apb_state_e        state_nxt_s;
    logic              cap_req_s;
    logic [DATA_W-1:0] rdata_nxt_s;
    logic              slverr_nxt_s;
    logic              timeout_nxt_s;
    logic              cnt_clr_s;
    logic              cnt_en_s;
    logic              expired_s;

    assign req_ready = (state_r == IDLE);
    assign cnt_clr_s = (state_r != ACCESS);
    assign cnt_en_s  = (state_r == ACCESS) && !pready;

    apb_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .pclk   (pclk),
        .preset (preset),
        .clr    (cnt_clr_s),
        .en     (cnt_en_s),
        .expired(expired_s)
    );

    // Next-state and next-response decode; response fields hold by default.
    always_comb begin
        state_nxt_s   = state_r;
        cap_req_s     = 1'b0;
        rdata_nxt_s   = rsp_rdata;
        slverr_nxt_s  = rsp_slverr;
        timeout_nxt_s = rsp_timeout;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    state_nxt_s = SETUP;
                    cap_req_s   = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SETUP: begin
                state_nxt_s = ACCESS;
            end
            ACCESS: begin
                // pready takes priority over a timeout expiring in the same cycle.
                if (pready) begin
                    state_nxt_s   = RESP;
                    rdata_nxt_s   = pwrite ? {DATA_W{1'b0}} : prdata;
                    slverr_nxt_s  = pslverr;
                    timeout_nxt_s = 1'b0;
                end else if (expired_s) begin
                    state_nxt_s   = RESP;
                    rdata_nxt_s   = {DATA_W{1'b0}};
                    slverr_nxt_s  = 1'b1;
                    timeout_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = ACCESS;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register plus registered APB and response outputs, decoded from the
    // next state so each output changes on the same edge as the state.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_r     <= IDLE;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= {ADDR_W{1'b0}};
            pwdata      <= {DATA_W{1'b0}};
            rsp_valid   <= 1'b0;
            rsp_rdata   <= {DATA_W{1'b0}};
            rsp_slverr  <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            psel        <= (state_nxt_s == SETUP) || (state_nxt_s == ACCESS);
            penable     <= (state_nxt_s == ACCESS);
            rsp_valid   <= (state_nxt_s == RESP);
            rsp_rdata   <= rdata_nxt_s;
            rsp_slverr  <= slverr_nxt_s;
            rsp_timeout <= timeout_nxt_s;
            if (cap_req_s) begin
                pwrite <= req_write;
                paddr  <= req_addr;
                pwdata <= req_wdata;
            end else begin
                pwrite <= pwrite;
                paddr  <= paddr;
                pwdata <= pwdata;
            end
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge against a small APB RAM completer model
// (64 words, word addressing, pready registered one cycle after penable,
// pslverr for addresses >= 64). Cycle 0 is the request-handshake cycle.
module tb_apb_master_bridge;

    logic        pclk = 1'b0;
    logic        preset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_slverr;
    logic        rsp_timeout;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    logic        stall;
    logic        mem_init;
    logic [31:0] mem [0:63];

    int passes = 0;
    int checks = 0;

    // results captured by run_xfer
    int          lat;
    logic [15:0] psel_h;
    logic [15:0] pen_h;
    logic [31:0] got_rdata;
    logic        got_slverr;
    logic        got_timeout;
    logic        acc_pwrite;
    logic [31:0] acc_paddr;
    logic [31:0] acc_pwdata;

    always #5 pclk = ~pclk;

    apb_master_bridge #(
        .ADDR_W        (32),
        .DATA_W        (32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .pclk       (pclk),
        .preset     (preset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_slverr (rsp_slverr),
        .rsp_timeout(rsp_timeout),
        .psel       (psel),
        .penable    (penable),
        .pwrite     (pwrite),
        .paddr      (paddr),
        .pwdata     (pwdata),
        .prdata     (prdata),
        .pready     (pready),
        .pslverr    (pslverr)
    );

    // APB RAM completer model
    always @(posedge pclk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
        end
        if (preset) begin
            pready  <= 1'b0;
            pslverr <= 1'b0;
            prdata  <= 32'h0;
        end else if (psel && penable && !pready && !stall) begin
            pready <= 1'b1;
            if (paddr < 32'd64) begin
                if (pwrite) mem[paddr[5:0]] <= pwdata;
                prdata  <= pwrite ? 32'h0 : mem[paddr[5:0]];
                pslverr <= 1'b0;
            end else begin
                prdata  <= 32'h0;
                pslverr <= 1'b1;
            end
        end else begin
            pready  <= 1'b0;
            pslverr <= 1'b0;
        end
    end

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One full transfer with rsp_ready held high; leaves the bench one cycle
    // after the response cycle (bridge back in IDLE).
    task automatic run_xfer(input logic w, input logic [31:0] a, input logic [31:0] d);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        rsp_ready = 1'b1;
        lat       = -1;
        psel_h    = 16'h0;
        pen_h     = 16'h0;
        for (int c = 0; c < 40 && lat < 0; c++) begin
            if (c < 16) begin
                psel_h[c] = psel;
                pen_h[c]  = penable;
            end
            if (c == 2) begin
                acc_pwrite = pwrite;
                acc_paddr  = paddr;
                acc_pwdata = pwdata;
            end
            if (rsp_valid) begin
                lat         = c;
                got_rdata   = rsp_rdata;
                got_slverr  = rsp_slverr;
                got_timeout = rsp_timeout;
            end
            step();
            if (c == 0) req_valid = 1'b0;
        end
    endtask

    initial begin
        preset    = 1'b1;
        mem_init  = 1'b1;
        stall     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        rsp_ready = 1'b0;
        step();
        step();
        mem_init = 1'b0;

        // reset state
        chk("rst_apb", {psel, penable, pwrite, paddr, pwdata}, 67'h0);
        chk("rst_rsp", {rsp_valid, rsp_slverr, rsp_timeout, rsp_rdata}, 35'h0);
        chk("rst_req_ready", req_ready, 1'b1);
        preset = 1'b0;
        step();

        // write 0x05 <- 0xDEADBEEF
        run_xfer(1'b1, 32'h5, 32'hDEADBEEF);
        chk("wr_psel_cycles", psel_h[7:0], 8'b0000_1110);
        chk("wr_penable_cycles", pen_h[7:0], 8'b0000_1100);
        chk("wr_latency", lat, 4);
        chk("wr_apb_fields", {acc_pwrite, acc_paddr, acc_pwdata}, {1'b1, 32'h5, 32'hDEADBEEF});
        chk("wr_rsp", {got_slverr, got_timeout, got_rdata}, {1'b0, 1'b0, 32'h0});
        chk("wr_back_idle", req_ready, 1'b1);

        // read-back 0x05
        run_xfer(1'b0, 32'h5, 32'h0);
        chk("rd_latency", lat, 4);
        chk("rd_rsp", {got_slverr, got_timeout, got_rdata}, {1'b0, 1'b0, 32'hDEADBEEF});

        // out-of-range write, then read 0x00
        run_xfer(1'b1, 32'h40, 32'h12345678);
        chk("oor_rsp", {got_slverr, got_timeout, got_rdata}, {1'b1, 1'b0, 32'h0});
        run_xfer(1'b0, 32'h0, 32'h0);
        chk("oor_read0", {got_slverr, got_rdata}, {1'b0, 32'h0});

        // timeout: completer never ready
        stall = 1'b1;
        run_xfer(1'b0, 32'h7, 32'h0);
        chk("to_latency", lat, 6);
        chk("to_psel_cycles", psel_h[7:0], 8'b0011_1110);
        chk("to_rsp", {got_slverr, got_timeout, got_rdata}, {1'b1, 1'b1, 32'h0});
        stall = 1'b0;

        // backpressure: hold rsp_ready low for 10 response cycles
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h5;
        rsp_ready = 1'b0;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 20 && !rsp_valid; i++) step();
        chk("bp_resp_seen", rsp_valid, 1'b1);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h6;
        req_wdata = 32'hCAFEF00D;
        for (int i = 0; i < 10; i++) begin
            chk("bp_hold", {rsp_valid, req_ready, psel, rsp_slverr, rsp_timeout, rsp_rdata},
                {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF});
            step();
        end
        rsp_ready = 1'b1;
        chk("bp_release_not_ready", req_ready, 1'b0);
        step();
        chk("bp_idle", {req_ready, psel, rsp_valid}, 3'b100);
        step();
        chk("bp_accept", {psel, penable, pwrite, paddr}, {1'b1, 1'b0, 1'b1, 32'h6});
        req_valid = 1'b0;
        for (int i = 0; i < 20 && !rsp_valid; i++) step();
        chk("bp_second_rsp", {rsp_valid, rsp_slverr}, 2'b10);
        step();
        run_xfer(1'b0, 32'h6, 32'h0);
        chk("bp_readback", {got_slverr, got_rdata}, {1'b0, 32'hCAFEF00D});

        // reset in ACCESS
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h5;
        step();
        req_valid = 1'b0;
        step();
        chk("mr_in_access", {psel, penable}, 2'b11);
        preset = 1'b1;
        step();
        chk("mr_dropped", {psel, penable, rsp_valid, req_ready}, 4'b0001);
        preset = 1'b0;
        step();
        run_xfer(1'b0, 32'h5, 32'h0);
        chk("mr_fresh_latency", lat, 4);
        chk("mr_fresh_rsp", {got_slverr, got_timeout, got_rdata}, {1'b0, 1'b0, 32'hDEADBEEF});

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/apb_master_bridge.md
# apb_master_bridge

Single-outstanding APB requester that sits directly upstream of the APB RAM slave. It accepts a simple valid/ready command (read or write, address, write data) from test or system logic and runs one full APB SETUP/ACCESS transfer. It waits for `pready`, with an optional timeout, and returns read data and error status on a valid/ready response channel.

## Interface
Parameters:
- `ADDR_W`, 32: width of `paddr` / `req_addr`.
- `DATA_W`, 32: width of `pwdata`, `prdata`, `req_wdata`, `rsp_rdata`.
- `TIMEOUT_CYCLES`, 16: maximum ACCESS cycles without `pready` before the transfer is aborted. 0 disables the timeout.

Ports:
- `pclk`  in  1  clock. Single clock domain; everything is sampled on its rising edge.
- `preset`  in  1  reset, synchronous, active-high.
- `req_valid`  in  1  command present.
- `req_ready`  out  1  bridge can accept a command.
- `req_write`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR_W  target address.
- `req_wdata`  in  DATA_W  write data; ignored for reads.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer takes the response.
- `rsp_rdata`  out  DATA_W  read data; 0 for writes and on error.
- `rsp_slverr`  out  1  slave error or timeout.
- `rsp_timeout`  out  1  transfer aborted by timeout.
- `psel`, `penable`, `pwrite`  out  1 each  APB controls.
- `paddr`  out  ADDR_W  APB address.
- `pwdata`  out  DATA_W  APB write data.
- `prdata`  in  DATA_W  APB read data.
- `pready`  in  1  APB ready.
- `pslverr`  in  1  APB error.

## Operation
- **IDLE**
  - `req_ready` = 1, combinational from state.
  - If `req_valid`, latch write/addr/wdata into `pwrite`/`paddr`/`pwdata`, then go to SETUP.
- **SETUP** (exactly one cycle)
  - `psel` = 1, `penable` = 0; go to ACCESS.
- **ACCESS**
  - `psel` = 1, `penable` = 1; `paddr`/`pwrite`/`pwdata` held stable.
  - On `pready` = 1: capture `rsp_rdata` = `pwrite` ? 0 : `prdata`, `rsp_slverr` = `pslverr`, `rsp_timeout` = 0; go to RESP.
  - Timeout counter increments each ACCESS cycle without `pready`.
  - If `TIMEOUT_CYCLES` ≠ 0, the count reaches `TIMEOUT_CYCLES`, and `pready` = 0: `rsp_slverr` = 1, `rsp_timeout` = 1, `rsp_rdata` = 0; go to RESP.
  - `pready` seen in the same cycle the count expires: `pready` wins.
- **RESP**
  - `psel` = 0, `penable` = 0, `rsp_valid` = 1, `req_ready` = 0.
  - Hold all `rsp_*` until `rsp_ready`, then go to IDLE. The counter clears.
- **Reset values**
  - All registered outputs 0: `psel`, `penable`, `pwrite`, `paddr`, `pwdata`, `rsp_valid`, `rsp_rdata`, `rsp_slverr`, `rsp_timeout`.
  - State = IDLE.
- **Reset mid-transfer**: at the next edge, state = IDLE, `psel`/`penable` drop, and any pending response is discarded.
- **Ordering**: no command is accepted while a transfer or response is outstanding. `req_valid` in any non-IDLE state is ignored, not queued.
- **Width**: the timeout counter is `$clog2(TIMEOUT_CYCLES+1)` bits, minimum 1, and saturates (never wraps).

## Timing
- Request handshake in cycle 0 → SETUP in cycle 1 → ACCESS from cycle 2.
- `pready` sampled high in cycle k → `rsp_valid` = 1 from cycle k+1.
- Against the APB RAM slave (registered `pready` one cycle after it sees `penable`):
  - `pready` = 1 in cycle 3.
  - `rsp_valid` = 1 in cycle 4.
  - Minimum request-to-response latency is 4 cycles.
- `rsp_ready` held high → IDLE in cycle 5, and the next command can be accepted in cycle 5. Throughput is one transfer per 5 cycles.
- Timeout path: `rsp_valid` asserts `TIMEOUT_CYCLES` + 2 cycles after the request handshake.
- All APB outputs are registered; no combinational path from `pready`/`prdata` to outputs. `req_ready` is decoded from state only.

## Structure
- Shared package `apb_pkg`:
  - `apb_state_e` enum {IDLE, SETUP, ACCESS, RESP}.
  - Default `ADDR_W`/`DATA_W` constants.
  - The RAM depth constant (64).
- One sub-module: `apb_timeout_counter` with ports `pclk`, `preset`, `clr`, `en`, `expired`, parameterized by `TIMEOUT_CYCLES`.
- The bridge connects to the slave through the existing APB interface, driving the `tb_top`-direction signals.

## Test plan
- **Write**: write addr 0x05, data 0xDEADBEEF against the RAM → `psel` in cycles 1–3, `penable` in cycles 2–3, `rsp_valid` in cycle 4, `rsp_slverr` = 0, `rsp_rdata` = 0.
- **Read-back**: read addr 0x05 after the write → `rsp_rdata` = 0xDEADBEEF, `rsp_slverr` = 0, latency 4 cycles.
- **Out-of-range**: write addr 0x40 (64) → `rsp_slverr` = 1, `rsp_timeout` = 0. A subsequent read of 0x00 returns 0, showing no memory corruption.
- **Timeout**: `pready` tied 0, `TIMEOUT_CYCLES` = 4 → `rsp_valid` in cycle 6, `rsp_slverr` = 1, `rsp_timeout` = 1, `psel` low in cycle 6.
- **Backpressure**: `rsp_ready` = 0 for 10 cycles → `rsp_*` stable, `req_ready` = 0, and a second `req_valid` is not accepted until the cycle after `rsp_ready` rises.
- **Mid-transfer reset**: `preset` = 1 in cycle 2 (ACCESS) → cycle 3 shows `psel` = `penable` = `rsp_valid` = 0 and state IDLE. A fresh read after release completes normally.
